// File: rtl/multdiv_iter_if.sv
// Operand/control/result bundle between a requester and the iterative multiply/divide unit.
// Latency: wires only; no storage.
// Backpressure: none; start pulses are fire-and-forget and results arrive as a one-cycle pulse.
//
// Ports (as signals):
//   data_operandA / data_operandB : signed operands, sampled only on a start edge
//   ctrl_MULT / ctrl_DIV          : one-cycle start pulses (multiply wins if both are high)
//   data_result / data_exception  : result word and overflow / divide-by-zero flag
//   data_resultRDY                : one-cycle completion pulse
interface multdiv_iter_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and 32/32 divide (restoring, on magnitudes).
// Latency: fixed 33 cycles from the start edge to the data_resultRDY pulse, for every operand value.
// Backpressure: none; a new start pulse aborts any operation in flight and restarts with new operands.
//
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; clears all state and outputs
//   bus   : multdiv_iter_if slave modport (operands, start pulses, result, exception, ready pulse)
module multdiv_iter (
  input  logic           clock,
  input  logic           reset,
  multdiv_iter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  logic [1:0]  state;
  logic [4:0]  iter_cnt;
  logic [31:0] mcand;      // multiplicand, or divisor magnitude
  logic [31:0] prod_hi;    // product upper half, or partial remainder
  logic [31:0] prod_lo;    // multiplier / product lower half, or dividend shifting into quotient
  logic        booth_bit;
  logic        op_div;
  logic        quo_neg;
  logic        div_zero;
  logic        div_ovf;

  // Shared 32-bit ALU: every iteration add/subtract goes through here.
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_b_eff;
  logic [31:0] alu_sum;
  logic        alu_cout;
  logic        alu_ovf;

  always_comb begin
    alu_b_eff = (alu_op == ALU_SUB) ? ~alu_b : alu_b;
    {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b_eff} + {32'd0, (alu_op == ALU_SUB)};
    alu_ovf = (alu_a[31] == alu_b_eff[31]) && (alu_sum[31] != alu_a[31]);
  end

  logic [1:0]  booth_pair;
  logic        booth_act;
  logic [31:0] rem_sh;
  logic [31:0] mult_acc;
  logic        mult_sign;

  always_comb begin
    booth_pair = {prod_lo[0], booth_bit};
    booth_act  = (booth_pair == 2'b01) || (booth_pair == 2'b10);
    rem_sh     = {prod_hi[30:0], prod_lo[31]};
    alu_a      = (state == ST_DIV) ? rem_sh : prod_hi;
    alu_b      = mcand;
    alu_op     = ((state == ST_DIV) || (booth_pair == 2'b10)) ? ALU_SUB : ALU_ADD;
    mult_acc   = booth_act ? alu_sum : prod_hi;
    // The add/subtract can overflow 32 bits (e.g. multiplicand 0x80000000); the true
    // sign of the 33-bit sum is what must be shifted in, so correct it with the ALU overflow.
    mult_sign  = booth_act ? (alu_sum[31] ^ alu_ovf) : prod_hi[31];
  end

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quo_signed;

  always_comb begin
    a_mag      = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
    b_mag      = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;
    quo_signed = quo_neg ? (32'd0 - prod_lo) : prod_lo;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= ST_IDLE;
      iter_cnt           <= 5'd0;
      mcand              <= 32'd0;
      prod_hi            <= 32'd0;
      prod_lo            <= 32'd0;
      booth_bit          <= 1'b0;
      op_div             <= 1'b0;
      quo_neg            <= 1'b0;
      div_zero           <= 1'b0;
      div_ovf            <= 1'b0;
      bus.data_result    <= 32'd0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (bus.ctrl_MULT) begin
        state     <= ST_MULT;
        iter_cnt  <= 5'd0;
        mcand     <= bus.data_operandA;
        prod_hi   <= 32'd0;
        prod_lo   <= bus.data_operandB;
        booth_bit <= 1'b0;
        op_div    <= 1'b0;
      end else if (bus.ctrl_DIV) begin
        state     <= ST_DIV;
        iter_cnt  <= 5'd0;
        mcand     <= b_mag;
        prod_hi   <= 32'd0;
        prod_lo   <= a_mag;
        booth_bit <= 1'b0;
        op_div    <= 1'b1;
        quo_neg   <= bus.data_operandA[31] ^ bus.data_operandB[31];
        div_zero  <= (bus.data_operandB == 32'd0);
        div_ovf   <= (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == 32'hFFFF_FFFF);
      end else begin
        case (state)
          ST_MULT: begin
            prod_hi   <= {mult_sign, mult_acc[31:1]};
            prod_lo   <= {mult_acc[0], prod_lo[31:1]};
            booth_bit <= prod_lo[0];
            iter_cnt  <= iter_cnt + 5'd1;
            if (iter_cnt == 5'd31) state <= ST_DONE;
          end
          ST_DIV: begin
            // Carry out of the subtract means no borrow: the trial fits, keep it.
            if (alu_cout) begin
              prod_hi <= alu_sum;
              prod_lo <= {prod_lo[30:0], 1'b1};
            end else begin
              prod_hi <= rem_sh;
              prod_lo <= {prod_lo[30:0], 1'b0};
            end
            iter_cnt <= iter_cnt + 5'd1;
            if (iter_cnt == 5'd31) state <= ST_DONE;
          end
          ST_DONE: begin
            state              <= ST_IDLE;
            bus.data_resultRDY <= 1'b1;
            if (op_div) begin
              bus.data_result    <= div_zero ? 32'd0 : quo_signed;
              bus.data_exception <= div_zero | div_ovf;
            end else begin
              bus.data_result    <= prod_lo;
              bus.data_exception <= (prod_hi != {32{prod_lo[31]}});
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: directed corner cases plus randomized multiply/divide with aborts.
// Latency: expects data_resultRDY exactly 33 edges after each surviving start edge.
// Backpressure: none; a newer start or a reset discards the pending expectation.
module tb_multdiv_iter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multdiv_iter_if bus ();

  multdiv_iter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] held_res = 32'd0;
  logic        held_exc = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    if (sb.size() == 0) begin
      chk("no_rdy_when_idle", {63'd0, bus.data_resultRDY}, 64'd0);
    end else if (bus.data_resultRDY) begin
      mon_e = sb.pop_front();
      chk("result", {32'd0, bus.data_result}, {32'd0, mon_e.res});
      chk("exception", {63'd0, bus.data_exception}, {63'd0, mon_e.exc});
      chk("rdy_cycle", 64'(cyc), 64'(mon_e.cyc));
      held_res = mon_e.res;
      held_exc = mon_e.exc;
    end
    if (!bus.data_resultRDY)
      chk("outputs_hold", {31'd0, bus.data_exception, bus.data_result}, {31'd0, held_exc, held_res});
  end

  // Reference model straight from the arithmetic definition.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p;
    int     q;
    @(negedge clock);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    sb.delete();
    if (m) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      q     = $signed(a) / $signed(b);
      e.res = q;
      e.exc = 1'b0;
    end
    e.cyc = cyc + 1 + 33;
    sb.push_back(e);
    @(negedge clock);
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
    held_res = 32'd0;
    held_exc = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'($urandom_range(0, 40)) - 32'd20;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd0;
      4: v = 32'($urandom_range(0, 65535));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    logic d;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset_result", {32'd0, bus.data_result}, 64'd0);
    chk("reset_exception", {63'd0, bus.data_exception}, 64'd0);
    chk("reset_rdy", {63'd0, bus.data_resultRDY}, 64'd0);
    reset = 1'b0;

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);          // 7 * -3
    drain();
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);  // product overflows 32 bits
    drain();
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);          // -7 / 2
    drain();
    start_op(1'b0, 1'b1, 32'd5, 32'd0);                  // divide by zero
    drain();
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  // most-negative / -1
    drain();

    // Multiply aborted by a divide started 10 cycles later.
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    idle(8);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    drain();

    // Reset at cycle 20 of a multiply; nothing may complete afterwards.
    start_op(1'b1, 1'b0, 32'd5, 32'd5);
    idle(18);
    do_reset(1);
    chk("midreset_result", {32'd0, bus.data_result}, 64'd0);
    chk("midreset_exception", {63'd0, bus.data_exception}, 64'd0);
    idle(40);
    start_op(1'b1, 1'b0, 32'd5, 32'd5);
    drain();

    // Both start pulses together: multiply.
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    drain();

    // Random mix, with random gaps so some operations are aborted by the next start.
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      d = m ? 1'($urandom_range(0, 1)) : 1'b1;
      start_op(m, d, pick(), pick());
      idle($urandom_range(0, 40));
    end
    drain();

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_iter.md
MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 The block SHALL provide these ports:
  clock  in  1  sole clock; all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  data_operandA  in  32  signed two's-complement operand A (multiplicand / dividend)
  data_operandB  in  32  signed two's-complement operand B (multiplier / divisor)
  ctrl_MULT  in  1  one-cycle start pulse, multiply A*B
  ctrl_DIV  in  1  one-cycle start pulse, divide A/B
  data_result  out  32  product low word or quotient
  data_exception  out  1  overflow / divide-by-zero flag, valid with data_resultRDY
  data_resultRDY  out  1  one-cycle completion pulse
REQ-002 Clock and reset SHALL be single-domain: one clock, reset synchronous and active-high, sampled only on the rising clock edge.

Function
REQ-003 The block SHALL implement states IDLE, MULT, DIV, DONE.
REQ-004 Start sampling: ctrl_MULT or ctrl_DIV high at a rising edge (start edge, cycle 0) SHALL latch data_operandA and data_operandB, clear the 5-bit iteration counter, and enter MULT or DIV.
REQ-005 Simultaneous ctrl_MULT and ctrl_DIV SHALL start a multiply; ctrl_DIV is ignored.
REQ-006 A start pulse in any state, including MULT/DIV mid-operation, SHALL abort the current operation without a data_resultRDY pulse and restart with the newly latched operands.
REQ-007 Operand inputs SHALL be ignored on all edges other than a start edge.
REQ-008 Multiply SHALL be radix-2 Booth: 64-bit product register plus Booth bit, one add/subtract/no-op of the 32-bit multiplicand into the upper half and one arithmetic right shift per cycle, 32 iterations (cycles 1..32).
REQ-009 Divide SHALL be restoring division on operand magnitudes: one 32-bit trial subtract and shift per cycle, 32 iterations (cycles 1..32); quotient negated when operand signs differ; remainder discarded; quotient truncates toward zero.
REQ-010 Every iteration add/subtract SHALL go through one 32-bit ALU add path (opcode 00000 add, 00001 subtract); no behavioral multiply or divide operators.
REQ-011 After iteration 32 the block SHALL enter DONE, then on the next edge drive data_resultRDY=1 for exactly one cycle (cycle 33 after start) and return to IDLE.
REQ-012 Latency SHALL be fixed at 33 cycles for all operand values, including exception cases.
REQ-013 Multiply result SHALL be product bits [31:0]; data_exception=1 iff product bits [63:32] are not all equal to product bit 31.
REQ-014 Divide by zero SHALL give data_result=0x00000000 and data_exception=1.
REQ-015 0x80000000 / 0xFFFFFFFF SHALL give data_result=0x80000000 and data_exception=1.
REQ-016 data_result and data_exception SHALL update only on the edge raising data_resultRDY and SHALL hold until the next completion or reset.
REQ-017 data_resultRDY SHALL never be high on two consecutive cycles and never high while another operation is in progress.

Reset
REQ-018 reset high at an edge SHALL force state IDLE, counter 0, internal registers 0, data_result=0, data_exception=0, data_resultRDY=0.
REQ-019 reset SHALL take priority over ctrl_MULT/ctrl_DIV on the same edge.
REQ-020 reset mid-operation SHALL abort with no data_resultRDY pulse; the next start SHALL behave as from power-up.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - MULT 7 * -3 -> RDY exactly cycle 33, result 0xFFFFFFEB, exception 0.
  - MULT 0x00010000 * 0x00010000 -> result 0x00000000, exception 1.
  - DIV -7 / 2 -> result 0xFFFFFFFD, exception 0; DIV 5 / 0 -> result 0, exception 1, RDY still cycle 33.
  - DIV 0x80000000 / -1 -> result 0x80000000, exception 1.
  - MULT 3*4, then DIV 100/7 pulsed at cycle 10 -> single RDY 33 cycles after DIV pulse, result 14; no RDY for the multiply.
  - reset at cycle 20 of MULT 5*5 -> no RDY, outputs 0; next MULT 5*5 -> result 25 at cycle 33.
  - ctrl_MULT and ctrl_DIV together with A=6, B=3 -> result 18 (multiply).
